frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Time-slot arbiter sharing one single-port synchronous frame-buffer RAM between the VGA display read path and a pixel writer (camera/CPU fill path). Sits between the VGA decoder outputs (pixel tick, DE, x/y) and the RAM. Guarantees one display read per pixel period during active video and hands every remaining RAM cycle to the writer. Also upscales a QVGA buffer to 640x480 by pixel replication.

## Interface
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- SCALE_SHIFT, 1, display-to-buffer coordinate right shift (1 = 2x replication)
- ADDR_W, 17, RAM address width (must hold FB_W*FB_H-1)
- DATA_W, 16, pixel width (RGB565)

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  asynchronous, active-low reset
- pclk_tick  input  1  one-clk pulse per pixel period (nominally every 4th clk)
- de  input  1  display-enable for the current x/y
- x_pixel  input  10  display column
- y_pixel  input  10  display row
- disp_data  output  DATA_W  pixel to the DAC/RGB output, registered
- wr_req  input  1  writer request (level)
- wr_addr  input  ADDR_W  write address, linear y*FB_W+x
- wr_data  input  DATA_W  write data
- wr_ack  output  1  request accepted this cycle (combinational)
- wr_oob  output  1  sticky flag: out-of-range write was accepted and dropped
- wr_stall_cnt  output  16  saturating count of cycles with wr_req=1 and wr_ack=0
- mem_addr  output  ADDR_W  RAM address, registered
- mem_we  output  1  RAM write enable, registered
- mem_wdata  output  DATA_W  RAM write data, registered
- mem_rdata  input  DATA_W  RAM read data, 1-cycle latency after mem_addr

## Operation
- Display slot: cycle T with pclk_tick=1 samples de, x_pixel, y_pixel. If de=1 and (y_pixel>>SCALE_SHIFT) < FB_H and (x_pixel>>SCALE_SHIFT) < FB_W: display owns the RAM port at T+1.
- Display address = (y_pixel>>SCALE_SHIFT)*FB_W + (x_pixel>>SCALE_SHIFT), truncated to ADDR_W; FB_W multiply is by constant.
- Display read pipeline states per sample: ISSUE (T+1: mem_addr=disp addr, mem_we=0), CAPTURE (T+2: mem_rdata valid, registered into disp_data, visible from T+3).
- Sample with de=0 or out of range: no read; disp_data loads 0 at the same T+3 point (blanking is black).
- Write path: wr_ack = wr_req & ~(pclk_tick & de_in_range). On ack in cycle t: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 at t+1. Writer may change request in the cycle after ack.
- Out-of-range write (wr_addr >= FB_W*FB_H): still acked; mem_we stays 0; wr_oob set, cleared only by reset.
- Idle port cycles: mem_we=0, mem_addr holds last value.
- wr_stall_cnt increments on each wr_req & ~wr_ack cycle, saturates at 0xFFFF.

## Timing
- Reset (reset=0, async): disp_data=0, mem_addr=0, mem_we=0, mem_wdata=0, wr_oob=0, wr_stall_cnt=0, pending read discarded. wr_ack is 0 while in reset.
- Display latency: tick T -> disp_data updated at T+3, held until next sample's T+3 (one pixel period lag; integrator compensates in the decoder).
- Write latency: ack at t, RAM write at t+1.
- Bandwidth: active video 3 writes per 4 clk; blanking 1 write per clk.
- Simultaneous tick (display slot) and wr_req: display wins, wr_ack=0, stall counted; writer acked the next cycle.
- Back-to-back pclk_tick: every tick issues its read; writer starved, no error.
- A read issue and a CAPTURE of an earlier read overlap legally; a write at T+2 does not corrupt the capture (read data already launched).
- Reset released mid-frame: first display read at next tick with in-range de=1.

## Test plan
- Reset: hold reset=0, drive wr_req=1 and ticks -> all outputs 0, no mem_we, wr_ack=0; release -> normal operation next cycle.
- Display read: preload RAM[161*320+10]=0xABCD, tick with de=1, x=20, y=322 -> mem_addr=51530 at T+1, disp_data=0xABCD at T+3.
- Contention: wr_req=1 continuously, ticks every 4 clk, de=1 -> wr_ack low exactly on tick cycles, 3 writes per 4 clk, wr_stall_cnt +1 per tick.
- Blanking: de=0 with ticks, wr_req=1 -> wr_ack every cycle, 1 write/clk, disp_data=0 at T+3.
- Out of range: wr_addr=76800 -> wr_ack=1, mem_we=0, wr_oob=1 sticky until reset.
- Saturation: hold wr_req=1 with back-to-back ticks and de=1 for 70000 clk -> wr_stall_cnt=0xFFFF, no wrap.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: time-slot arbiter sharing one single-port frame-buffer
// RAM between the VGA display read path and a pixel writer.
//
// Ports:
//   clk, reset (async, active low)
//   pclk_tick, de, x_pixel, y_pixel : display timing from the VGA decoder
//   disp_data                       : registered pixel to the RGB output
//   wr_req, wr_addr, wr_data        : writer request (level) with linear address
//   wr_ack                          : combinational accept for this cycle
//   wr_oob                          : sticky, an out-of-range write was dropped
//   wr_stall_cnt                    : saturating count of refused request cycles
//   mem_addr, mem_we, mem_wdata     : registered RAM port
//   mem_rdata                       : RAM read data, one cycle after mem_addr
//
// Display pixels are replicated by 2**SCALE_SHIFT in both directions, so a
// QVGA buffer fills a 640x480 screen.

module frame_buffer_arbiter #(
   parameter int FB_W        = 320,
   parameter int FB_H        = 240,
   parameter int SCALE_SHIFT = 1,
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pclk_tick,
   input  logic              de,
   input  logic [9:0]        x_pixel,
   input  logic [9:0]        y_pixel,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_oob,
   output logic [15:0]       wr_stall_cnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [9:0]        FB_W_L  = 10'(FB_W);
   localparam logic [9:0]        FB_H_L  = 10'(FB_H);
   localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
   localparam logic [15:0]       CNT_MAX = 16'hFFFF;

   // ------------------------------------------------------------------
   // Display slot decode
   // ------------------------------------------------------------------
   logic [9:0]        x_buf;
   logic [9:0]        y_buf;
   logic              in_range;
   logic              disp_slot;
   logic [ADDR_W-1:0] disp_addr;

   assign x_buf     = x_pixel >> SCALE_SHIFT;
   assign y_buf     = y_pixel >> SCALE_SHIFT;
   assign in_range  = (x_buf < FB_W_L) && (y_buf < FB_H_L);
   assign disp_slot = pclk_tick & de & in_range;

   // Constant multiply; the result is deliberately truncated to ADDR_W.
   assign disp_addr = ADDR_W'(y_buf) * ADDR_W'(FB_W) + ADDR_W'(x_buf);

   // ------------------------------------------------------------------
   // Write path accept
   // ------------------------------------------------------------------
   logic wr_valid;
   logic wr_commit;
   logic wr_drop;
   logic stall_ev;

   // The display slot always wins the port; reset blocks all accepts.
   assign wr_ack    = reset & wr_req & ~disp_slot;
   assign wr_valid  = wr_addr < FB_SIZE;
   assign wr_commit = wr_ack & wr_valid;
   assign wr_drop   = wr_ack & ~wr_valid;
   assign stall_ev  = reset & wr_req & ~wr_ack;

   // ------------------------------------------------------------------
   // RAM port mux
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_nx;
   logic              we_nx;
   logic [DATA_W-1:0] wdata_nx;

   always_comb begin
      addr_nx  = mem_addr;
      we_nx    = 1'b0;
      wdata_nx = mem_wdata;
      unique case (1'b1)
         disp_slot: begin
            addr_nx = disp_addr;
         end
         wr_commit: begin
            addr_nx  = wr_addr;
            we_nx    = 1'b1;
            wdata_nx = wr_data;
         end
         default: begin
            // Idle or dropped write: address holds, no strobe.
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         mem_addr  <= addr_nx;
         mem_we    <= we_nx;
         mem_wdata <= wdata_nx;
      end
   end

   // ------------------------------------------------------------------
   // Display read pipeline: ISSUE (q1) then CAPTURE (q2)
   // ------------------------------------------------------------------
   // Every tick travels down the pipe so that a blank or out-of-range
   // sample still reloads disp_data with black at the same point.
   logic tick_q1;
   logic hit_q1;
   logic tick_q2;
   logic hit_q2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q1 <= 1'b0;
         hit_q1  <= 1'b0;
         tick_q2 <= 1'b0;
         hit_q2  <= 1'b0;
      end else begin
         tick_q1 <= pclk_tick;
         hit_q1  <= disp_slot;
         tick_q2 <= tick_q1;
         hit_q2  <= hit_q1;
      end
   end

   // mem_rdata is valid in the CAPTURE cycle; a write issued in this
   // same cycle lands after the read data was already launched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_data <= '0;
      end else if (tick_q2) begin
         disp_data <= hit_q2 ? mem_rdata : '0;
      end
   end

   // ------------------------------------------------------------------
   // Writer status
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_oob <= 1'b0;
      end else if (wr_drop) begin
         wr_oob <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_stall_cnt <= '0;
      end else if (stall_ev && wr_stall_cnt != CNT_MAX) begin
         wr_stall_cnt <= wr_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: randomized self-checking bench for
// frame_buffer_arbiter, with a behavioural RAM and reference model.

module tb_frame_buffer_arbiter;

   localparam int NPIX = 320 * 240;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pclk_tick = 1'b0;
   logic        de = 1'b0;
   logic [9:0]  x_pixel = '0;
   logic [9:0]  y_pixel = '0;
   logic [15:0] disp_data;
   logic        wr_req = 1'b0;
   logic [16:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_ack;
   logic        wr_oob;
   logic [15:0] wr_stall_cnt;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;

   frame_buffer_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .pclk_tick    (pclk_tick),
      .de           (de),
      .x_pixel      (x_pixel),
      .y_pixel      (y_pixel),
      .disp_data    (disp_data),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .wr_oob       (wr_oob),
      .wr_stall_cnt (wr_stall_cnt),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input int i);
      return 16'((i * 40503) ^ 32'h5a5a);
   endfunction

   // Behavioural single-port RAM, read-before-write, 1-cycle latency.
   logic [15:0] ram [0:NPIX-1];
   initial begin
      for (int i = 0; i < NPIX; i++) ram[i] = pat(i);
      forever begin
         @(posedge clk);
         if (int'(mem_addr) < NPIX) begin
            mem_rdata <= ram[int'(mem_addr)];
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
         end else begin
            mem_rdata <= 16'h0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------
   logic [15:0] mdl [0:NPIX-1];
   logic        e_ack;
   logic [16:0] e_addr;
   logic        e_we;
   logic [15:0] e_wdata;
   logic        e_oob;
   int          e_stall;
   logic [15:0] e_disp;
   int          due_q [$];
   logic [15:0] val_q [$];
   int          cyc;
   logic        ack_seen;
   int          vec;
   int          errs;

   function automatic bit in_fb(input bit d, input int x, input int y);
      return d && (x / 2 < 320) && (y / 2 < 240);
   endfunction

   function automatic int fb_index(input int x, input int y);
      return (y / 2) * 320 + (x / 2);
   endfunction

   // One clock: drive at negedge, sample wr_ack, advance model,
   // return at posedge+1 with registered outputs settled.
   task automatic drive_cycle(input bit rv, input bit t, input bit d,
                              input int x, input int y, input bit r,
                              input int a, input logic [15:0] wd);
      bit slot;
      @(negedge clk);
      reset     = rv;
      pclk_tick = t;
      de        = d;
      x_pixel   = 10'(x);
      y_pixel   = 10'(y);
      wr_req    = r;
      wr_addr   = 17'(a);
      wr_data   = wd;
      #1;
      ack_seen = wr_ack;
      if (!rv) begin
         e_ack = 0; e_addr = '0; e_we = 0; e_wdata = '0;
         e_oob = 0; e_stall = 0; e_disp = '0;
         due_q.delete();
         val_q.delete();
      end else begin
         slot  = t && in_fb(d, x, y);
         e_ack = r && !slot;
         e_we  = 0;
         if (slot) begin
            e_addr = 17'(fb_index(x, y));
         end else if (e_ack && a < NPIX) begin
            e_addr  = 17'(a);
            e_we    = 1;
            e_wdata = wd;
            mdl[a]  = wd;
         end else if (e_ack) begin
            e_oob = 1;
         end
         if (r && !e_ack && e_stall < 65535) e_stall++;
         if (t) begin
            due_q.push_back(cyc + 3);
            val_q.push_back(slot ? mdl[fb_index(x, y)] : 16'h0);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      while (due_q.size() > 0 && due_q[0] == cyc) begin
         e_disp = val_q.pop_front();
         void'(due_q.pop_front());
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(0, 1, 1, 20, 322, 1, i * 5, 16'h1234);
         vec++;
         if (ack_seen !== 1'b0) begin
            errs++; $display("FAIL rst_ack got=%b want=0", ack_seen);
         end
         vec++;
         if (mem_we !== 1'b0) begin
            errs++; $display("FAIL rst_we got=%b want=0", mem_we);
         end
         vec++;
         if (mem_addr !== 17'h0) begin
            errs++; $display("FAIL rst_addr got=%h want=0", mem_addr);
         end
         vec++;
         if (mem_wdata !== 16'h0) begin
            errs++; $display("FAIL rst_wdata got=%h want=0", mem_wdata);
         end
         vec++;
         if (disp_data !== 16'h0) begin
            errs++; $display("FAIL rst_disp got=%h want=0", disp_data);
         end
         vec++;
         if (wr_oob !== 1'b0 || wr_stall_cnt !== 16'h0) begin
            errs++;
            $display("FAIL rst_stat got=%b/%h want=0/0", wr_oob, wr_stall_cnt);
         end
      end
      drive_cycle(1, 0, 0, 0, 0, 1, 100, 16'h5555);
      vec++;
      if (ack_seen !== 1'b1) begin
         errs++; $display("FAIL rel_ack got=%b want=1", ack_seen);
      end
      vec++;
      if (mem_we !== 1'b1 || mem_addr !== 17'd100) begin
         errs++;
         $display("FAIL rel_wr got=%b/%0d want=1/100", mem_we, mem_addr);
      end
   endtask

   task automatic test_display_read();
      drive_cycle(1, 0, 0, 0, 0, 1, 51530, 16'hABCD);
      vec++;
      if (ack_seen !== 1'b1 || mem_we !== 1'b1) begin
         errs++;
         $display("FAIL pre_wr got=%b/%b want=1/1", ack_seen, mem_we);
      end
      vec++;
      if (mem_addr !== 17'd51530 || mem_wdata !== 16'hABCD) begin
         errs++;
         $display("FAIL pre_data got=%0d/%h want=51530/abcd",
                  mem_addr, mem_wdata);
      end
      drive_cycle(1, 0, 0, 0, 0, 1, 7, 16'h2222);
      drive_cycle(1, 1, 1, 20, 322, 1, 5, 16'h1111);
      vec++;
      if (ack_seen !== 1'b0) begin
         errs++; $display("FAIL rd_ack got=%b want=0", ack_seen);
      end
      vec++;
      if (mem_addr !== 17'd51530 || mem_we !== 1'b0) begin
         errs++;
         $display("FAIL rd_issue got=%0d/%b want=51530/0", mem_addr, mem_we);
      end
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
      vec++;
      if (disp_data !== e_disp) begin
         errs++; $display("FAIL rd_early got=%h want=%h", disp_data, e_disp);
      end
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
      vec++;
      if (disp_data !== 16'hABCD || e_disp !== 16'hABCD) begin
         errs++; $display("FAIL rd_data got=%h want=abcd", disp_data);
      end
   endtask

   task automatic test_contention();
      int nwe = 0;
      int nlow = 0;
      int s0 = e_stall;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1, (i % 4) == 0, 1, int'($urandom_range(639)),
                     int'($urandom_range(479)), 1,
                     int'($urandom_range(NPIX - 1)), 16'($urandom));
         if (!ack_seen) nlow++;
         if (mem_we) nwe++;
         vec++;
         if (ack_seen !== e_ack) begin
            errs++; $display("FAIL ct_ack got=%b want=%b", ack_seen, e_ack);
         end
         vec++;
         if (mem_we !== e_we || mem_addr !== e_addr) begin
            errs++;
            $display("FAIL ct_port got=%b/%h want=%b/%h",
                     mem_we, mem_addr, e_we, e_addr);
         end
         vec++;
         if (mem_wdata !== e_wdata) begin
            errs++; $display("FAIL ct_wdata got=%h want=%h", mem_wdata, e_wdata);
         end
         vec++;
         if (disp_data !== e_disp) begin
            errs++; $display("FAIL ct_disp got=%h want=%h", disp_data, e_disp);
         end
      end
      vec++;
      if (nwe != 30 || nlow != 10) begin
         errs++; $display("FAIL ct_bw got=%0d/%0d want=30/10", nwe, nlow);
      end
      vec++;
      if (wr_stall_cnt !== 16'(s0 + 10)) begin
         errs++; $display("FAIL ct_stall got=%0d want=%0d", wr_stall_cnt, s0 + 10);
      end
   endtask

   task automatic test_blanking();
      int nack = 0;
      for (int i = 0; i < 24; i++) begin
         drive_cycle(1, (i % 4) == 0, 0, int'($urandom_range(639)),
                     int'($urandom_range(479)), 1,
                     int'($urandom_range(NPIX - 1)), 16'($urandom));
         if (ack_seen) nack++;
         vec++;
         if (mem_we !== 1'b1 || mem_addr !== e_addr) begin
            errs++;
            $display("FAIL bl_port got=%b/%h want=1/%h", mem_we, mem_addr, e_addr);
         end
         vec++;
         if (mem_wdata !== e_wdata) begin
            errs++; $display("FAIL bl_wdata got=%h want=%h", mem_wdata, e_wdata);
         end
         vec++;
         if (disp_data !== e_disp) begin
            errs++; $display("FAIL bl_disp got=%h want=%h", disp_data, e_disp);
         end
      end
      vec++;
      if (nack != 24) begin
         errs++; $display("FAIL bl_acks got=%0d want=24", nack);
      end
      vec++;
      if (disp_data !== 16'h0) begin
         errs++; $display("FAIL bl_black got=%h want=0", disp_data);
      end
   endtask

   task automatic test_oob();
      logic [16:0] hold;
      hold = e_addr;
      drive_cycle(1, 0, 0, 0, 0, 1, NPIX, 16'hDEAD);
      vec++;
      if (ack_seen !== 1'b1) begin
         errs++; $display("FAIL oob_ack got=%b want=1", ack_seen);
      end
      vec++;
      if (mem_we !== 1'b0 || mem_addr !== hold) begin
         errs++;
         $display("FAIL oob_port got=%b/%h want=0/%h", mem_we, mem_addr, hold);
      end
      vec++;
      if (wr_oob !== 1'b1) begin
         errs++; $display("FAIL oob_flag got=%b want=1", wr_oob);
      end
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1, 0, 0, 0, 0, 1,
                     int'($urandom_range(NPIX + 999)), 16'($urandom));
         vec++;
         if (wr_oob !== 1'b1) begin
            errs++; $display("FAIL oob_sticky got=%b want=1", wr_oob);
         end
         vec++;
         if (mem_we !== e_we || mem_addr !== e_addr) begin
            errs++;
            $display("FAIL oob_mix got=%b/%h want=%b/%h",
                     mem_we, mem_addr, e_we, e_addr);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         drive_cycle(1, 1, 1, int'($urandom_range(639)),
                     int'($urandom_range(479)), 1,
                     int'($urandom_range(NPIX - 1)), 16'($urandom));
         vec++;
         if (ack_seen !== 1'b0 || mem_we !== 1'b0) begin
            errs++;
            $display("FAIL b2b_starve got=%b/%b want=0/0", ack_seen, mem_we);
         end
         vec++;
         if (mem_addr !== e_addr) begin
            errs++; $display("FAIL b2b_addr got=%h want=%h", mem_addr, e_addr);
         end
         vec++;
         if (disp_data !== e_disp) begin
            errs++; $display("FAIL b2b_disp got=%h want=%h", disp_data, e_disp);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         drive_cycle(1, $urandom_range(3) == 0, 1'($urandom),
                     int'($urandom_range(799)), int'($urandom_range(524)),
                     1'($urandom), int'($urandom_range(NPIX + 3000)),
                     16'($urandom));
         vec++;
         if (ack_seen !== e_ack) begin
            errs++; $display("FAIL rnd_ack got=%b want=%b", ack_seen, e_ack);
         end
         vec++;
         if (mem_we !== e_we || mem_addr !== e_addr) begin
            errs++;
            $display("FAIL rnd_port got=%b/%h want=%b/%h",
                     mem_we, mem_addr, e_we, e_addr);
         end
         vec++;
         if (mem_wdata !== e_wdata) begin
            errs++; $display("FAIL rnd_wdata got=%h want=%h", mem_wdata, e_wdata);
         end
         vec++;
         if (wr_oob !== e_oob || wr_stall_cnt !== 16'(e_stall)) begin
            errs++;
            $display("FAIL rnd_stat got=%b/%0d want=%b/%0d",
                     wr_oob, wr_stall_cnt, e_oob, e_stall);
         end
         vec++;
         if (disp_data !== e_disp) begin
            errs++; $display("FAIL rnd_disp got=%h want=%h", disp_data, e_disp);
         end
      end
   endtask

   task automatic test_reset_midframe();
      drive_cycle(1, 1, 1, 100, 100, 0, 0, 16'h0);
      #2 reset = 1'b0;
      #1;
      vec++;
      if (disp_data !== 16'h0 || mem_addr !== 17'h0 || mem_we !== 1'b0) begin
         errs++;
         $display("FAIL mid_async got=%h/%h/%b want=0/0/0",
                  disp_data, mem_addr, mem_we);
      end
      vec++;
      if (wr_oob !== 1'b0 || wr_stall_cnt !== 16'h0) begin
         errs++;
         $display("FAIL mid_stat got=%b/%h want=0/0", wr_oob, wr_stall_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 0, 0, 0, 0, 1, 3, 16'h0);
         vec++;
         if (disp_data !== 16'h0 || ack_seen !== 1'b0) begin
            errs++;
            $display("FAIL mid_hold got=%h/%b want=0/0", disp_data, ack_seen);
         end
      end
      drive_cycle(1, 1, 1, 300, 200, 0, 0, 16'h0);
      vec++;
      if (mem_addr !== 17'(fb_index(300, 200)) || mem_we !== 1'b0) begin
         errs++;
         $display("FAIL mid_issue got=%0d want=%0d", mem_addr, fb_index(300, 200));
      end
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
      vec++;
      if (disp_data !== mdl[fb_index(300, 200)] || disp_data !== e_disp) begin
         errs++;
         $display("FAIL mid_read got=%h want=%h", disp_data, mdl[fb_index(300, 200)]);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 65600; i++) begin
         drive_cycle(1, 1, 1, int'($urandom_range(639)),
                     int'($urandom_range(479)), 1, 0, 16'h0);
      end
      vec++;
      if (wr_stall_cnt !== 16'hFFFF || e_stall != 65535) begin
         errs++; $display("FAIL sat_max got=%h want=ffff", wr_stall_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1, 1, 1, 10, 10, 1, 0, 16'h0);
      end
      vec++;
      if (wr_stall_cnt !== 16'hFFFF) begin
         errs++; $display("FAIL sat_nowrap got=%h want=ffff", wr_stall_cnt);
      end
      vec++;
      if (disp_data !== e_disp) begin
         errs++; $display("FAIL sat_disp got=%h want=%h", disp_data, e_disp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec = 0; errs = 0; cyc = 0;
      e_ack = 0; e_addr = '0; e_we = 0; e_wdata = '0;
      e_oob = 0; e_stall = 0; e_disp = '0;
      for (int i = 0; i < NPIX; i++) mdl[i] = pat(i);
      #1 reset = 1'b0;
      test_reset();
      test_display_read();
      test_contention();
      test_blanking();
      test_oob();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
